// File: rtl/axi_cdc_isolate_pkg.sv
// rtl/axi_cdc_isolate_pkg.sv - shared state encoding, counter sizing and default AXI channel types
package axi_cdc_isolate_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } iso_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_def_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_def_t;

endpackage

// File: rtl/axi_cdc_isolate_cnt.sv
// rtl/axi_cdc_isolate_cnt.sv - outstanding-transaction up/down counter with simultaneous inc/dec
module axi_cdc_isolate_cnt
    import axi_cdc_isolate_pkg::*;
#(
    parameter int unsigned Max = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       inc_i,
    input  logic                       dec_i,
    output logic [cnt_width(Max)-1:0]  count_o,
    output logic                       at_max_o,
    output logic                       is_zero_o
);

    localparam int unsigned Width = cnt_width(Max);
    localparam logic [Width-1:0] MaxVal = Width'(Max);
    localparam logic [Width-1:0] One    = Width'(1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + One;
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - One;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o   = cnt_q;
    assign at_max_o  = (cnt_q == MaxVal);
    assign is_zero_o = (cnt_q == '0);

    // The gating upstream must make these unreachable.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(inc_i && !dec_i && at_max_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(dec_i && !inc_i && is_zero_o));

endmodule

// File: rtl/axi_cdc_isolate.sv
// rtl/axi_cdc_isolate.sv - AXI fence that limits, drains and isolates traffic ahead of a CDC
module axi_cdc_isolate
    import axi_cdc_isolate_pkg::*;
#(
    parameter int unsigned MaxWrTxns = 8,
    parameter int unsigned MaxRdTxns = 8,
    parameter type axi_req_t  = axi_req_def_t,
    parameter type axi_resp_t = axi_resp_def_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    input  logic      isolate_i,
    output logic      isolated_o
);

    iso_state_e state_q, state_d;
    logic       isolated_q;
    logic       aw_stall_q, aw_stall_d, ar_stall_q, ar_stall_d;
    logic       aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
    logic       aw_open, ar_open, w_open, drained;
    logic       wr_at_max, wr_zero, rd_at_max, rd_zero, w_at_max, w_zero;

    logic [cnt_width(MaxWrTxns)-1:0] wr_count, w_count;
    logic [cnt_width(MaxRdTxns)-1:0] rd_count;
    logic                            unused_cnt;

    assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    // A completing response frees its slot in the same cycle, so a blocked request can follow at once.
    assign aw_open = aw_stall_q | ((state_q == NORMAL) & (~wr_at_max | b_hs));
    assign ar_open = ar_stall_q | ((state_q == NORMAL) & (~rd_at_max | r_last_hs));

    always_comb begin
        w_open = 1'b0;
        unique case (state_q)
            NORMAL:  w_open = 1'b1;
            DRAIN:   w_open = ~w_zero;
            default: w_open = 1'b0;
        endcase
    end

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_open;
        mst_req_o.w_valid  = slv_req_i.w_valid & w_open;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_open;
    end

    always_comb begin
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_open;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
    end

    assign aw_stall_d = mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
    assign ar_stall_d = mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
    assign drained    = wr_zero & rd_zero & w_zero & ~aw_stall_q & ~ar_stall_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORMAL:   if (isolate_i) state_d = DRAIN;
            DRAIN: begin
                if (!isolate_i) begin
                    state_d = NORMAL;
                end else if (drained) begin
                    state_d = ISOLATED;
                end
            end
            ISOLATED: if (!isolate_i) state_d = NORMAL;
            default:  state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= NORMAL;
            isolated_q <= 1'b0;
            aw_stall_q <= 1'b0;
            ar_stall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            isolated_q <= (state_d == ISOLATED);
            aw_stall_q <= aw_stall_d;
            ar_stall_q <= ar_stall_d;
        end
    end

    assign isolated_o = isolated_q;

    axi_cdc_isolate_cnt #(.Max(MaxWrTxns)) u_wr_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (aw_hs),
        .dec_i     (b_hs),
        .count_o   (wr_count),
        .at_max_o  (wr_at_max),
        .is_zero_o (wr_zero)
    );

    axi_cdc_isolate_cnt #(.Max(MaxRdTxns)) u_rd_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (ar_hs),
        .dec_i     (r_last_hs),
        .count_o   (rd_count),
        .at_max_o  (rd_at_max),
        .is_zero_o (rd_zero)
    );

    // Bursts whose AW has been accepted but whose last W beat has not yet passed.
    axi_cdc_isolate_cnt #(.Max(MaxWrTxns)) u_w_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (aw_hs),
        .dec_i     (w_last_hs),
        .count_o   (w_count),
        .at_max_o  (w_at_max),
        .is_zero_o (w_zero)
    );

    assign unused_cnt = ^{wr_count, rd_count, w_count, w_at_max};

endmodule

// File: tb/tb_axi_cdc_isolate.sv
// tb/tb_axi_cdc_isolate.sv - scoreboard bench for the AXI CDC isolation fence
module tb_axi_cdc_isolate;
    import axi_cdc_isolate_pkg::*;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          isolate_i;
    logic          isolated_o;
    axi_req_def_t  slv_req, mst_req;
    axi_resp_def_t slv_resp, mst_resp;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_r[$];

    always #5 clk = ~clk;

    axi_cdc_isolate #(
        .MaxWrTxns (2),
        .MaxRdTxns (8),
        .axi_req_t (axi_req_def_t),
        .axi_resp_t(axi_resp_def_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .slv_req_i (slv_req),
        .slv_resp_o(slv_resp),
        .mst_req_o (mst_req),
        .mst_resp_i(mst_resp),
        .isolate_i (isolate_i),
        .isolated_o(isolated_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: handshake with empty expectation queue at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv_aw(input logic v, input logic [31:0] a, input logic [7:0] len);
        slv_req.aw_valid = v;
        slv_req.aw.addr  = a;
        slv_req.aw.len   = len;
    endtask

    task automatic drv_ar(input logic v, input logic [31:0] a, input logic [7:0] len);
        slv_req.ar_valid = v;
        slv_req.ar.addr  = a;
        slv_req.ar.len   = len;
    endtask

    task automatic drv_w(input logic v, input logic [31:0] d, input logic last);
        slv_req.w_valid = v;
        slv_req.w.data  = d;
        slv_req.w.strb  = 4'hf;
        slv_req.w.last  = last;
    endtask

    task automatic drv_b(input logic v, input logic [3:0] id);
        mst_resp.b_valid = v;
        mst_resp.b.id    = id;
    endtask

    task automatic drv_r(input logic v, input logic [31:0] d, input logic last);
        mst_resp.r_valid = v;
        mst_resp.r.data  = d;
        mst_resp.r.last  = last;
    endtask

    // Monitor: every handshake the DUT presents consumes one expected payload.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (mst_req.aw_valid && mst_resp.aw_ready) begin
                if (exp_aw.size() == 0) miss("aw_extra");
                else chk("aw_addr", mst_req.aw.addr, exp_aw.pop_front());
            end
            if (mst_req.w_valid && mst_resp.w_ready) begin
                if (exp_w.size() == 0) miss("w_extra");
                else chk("w_data", mst_req.w.data, exp_w.pop_front());
            end
            if (mst_req.ar_valid && mst_resp.ar_ready) begin
                if (exp_ar.size() == 0) miss("ar_extra");
                else chk("ar_addr", mst_req.ar.addr, exp_ar.pop_front());
            end
            if (slv_resp.b_valid && slv_req.b_ready) begin
                if (exp_b.size() == 0) miss("b_extra");
                else chk("b_id", 32'(slv_resp.b.id), exp_b.pop_front());
            end
            if (slv_resp.r_valid && slv_req.r_ready) begin
                if (exp_r.size() == 0) miss("r_extra");
                else chk("r_data", slv_resp.r.data, exp_r.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        slv_req   = '0;
        mst_resp  = '0;
        slv_req.b_ready  = 1'b1;
        slv_req.r_ready  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b0;
        slv_req.ar_valid  = 1'b1;
        isolate_i = 1'b0;
        rst_ni    = 1'b0;

        // Reset: NORMAL gating with zero counts
        tick();
        mid();
        chk("rst_isolated", isolated_o, 0);
        chk("rst_aw_ready", slv_resp.aw_ready, 1);
        chk("rst_mst_ar_valid", mst_req.ar_valid, 1);
        tick();
        rst_ni = 1'b1;
        slv_req.ar_valid  = 1'b0;
        mst_resp.ar_ready = 1'b1;

        // Passthrough: back-to-back AW/W/AR, responses overlapping
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) begin
                drv_aw(1, 32'h100 + i, 0);
                drv_w(1, 32'ha0 + i, 1);
                drv_ar(1, 32'h200 + i, 0);
                exp_aw.push_back(32'h100 + i);
                exp_w.push_back(32'ha0 + i);
                exp_ar.push_back(32'h200 + i);
            end else begin
                drv_aw(0, 0, 0);
                drv_w(0, 0, 0);
                drv_ar(0, 0, 0);
            end
            if (i >= 1 && i <= 4) begin
                drv_b(1, 4'(i - 1));
                drv_r(1, 32'hd0 + i - 1, 1);
                exp_b.push_back(i - 1);
                exp_r.push_back(32'hd0 + i - 1);
            end else begin
                drv_b(0, 0);
                drv_r(0, 0, 0);
            end
            mid();
            if (i < 4) begin
                chk("pt_aw_ready", slv_resp.aw_ready, 1);
                chk("pt_mst_aw_valid", mst_req.aw_valid, 1);
                chk("pt_w_ready", slv_resp.w_ready, 1);
                chk("pt_ar_ready", slv_resp.ar_ready, 1);
            end
            chk("pt_isolated", isolated_o, 0);
        end

        // Limit: third AW waits for the first B and is accepted in that cycle
        tick(); drv_aw(1, 32'h300, 0); drv_w(1, 32'hb0, 1);
        exp_aw.push_back(32'h300); exp_w.push_back(32'hb0);
        tick(); drv_aw(1, 32'h310, 0); drv_w(1, 32'hb1, 1);
        exp_aw.push_back(32'h310); exp_w.push_back(32'hb1);
        tick(); drv_aw(1, 32'h320, 0); drv_w(0, 0, 0);
        exp_aw.push_back(32'h320);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("lim_aw_ready_blocked", slv_resp.aw_ready, 0);
            chk("lim_mst_aw_valid_blocked", mst_req.aw_valid, 0);
            tick();
        end
        drv_b(1, 4'd0); exp_b.push_back(0);
        mid();
        chk("lim_aw_ready_on_b", slv_resp.aw_ready, 1);
        tick(); drv_aw(0, 0, 0); drv_w(1, 32'hb2, 1); drv_b(1, 4'd1);
        exp_w.push_back(32'hb2); exp_b.push_back(1);
        tick(); drv_w(0, 0, 0); drv_b(1, 4'd2); exp_b.push_back(2);
        tick(); drv_b(0, 0);

        // Drain: two 4-beat writes and one 8-beat read outstanding
        tick(); drv_aw(1, 32'h400, 3); exp_aw.push_back(32'h400);
        tick(); drv_aw(1, 32'h410, 3); drv_ar(1, 32'h500, 7);
        exp_aw.push_back(32'h410); exp_ar.push_back(32'h500);
        tick(); drv_aw(0, 0, 0); drv_ar(0, 0, 0); isolate_i = 1'b1;
        mid();
        chk("drn_isolated_early", isolated_o, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) begin
                drv_aw(1, 32'h420, 0); drv_ar(1, 32'h520, 0);
                exp_aw.push_back(32'h420); exp_ar.push_back(32'h520);
            end
            drv_w(1, 32'hc0 + k, (k == 3) || (k == 7));
            drv_r(1, 32'he0 + k, k == 7);
            exp_w.push_back(32'hc0 + k); exp_r.push_back(32'he0 + k);
            if (k == 4) begin
                drv_b(1, 4'd4); exp_b.push_back(4);
            end else begin
                drv_b(0, 0);
            end
            mid();
            chk("drn_aw_ready_blocked", slv_resp.aw_ready, 0);
            chk("drn_mst_ar_valid_blocked", mst_req.ar_valid, 0);
            chk("drn_w_ready", slv_resp.w_ready, 1);
            chk("drn_isolated_busy", isolated_o, 0);
        end
        tick(); drv_w(0, 0, 0); drv_r(0, 0, 0); drv_b(1, 4'd5); exp_b.push_back(5);
        mid(); chk("drn_isolated_last_b", isolated_o, 0);
        tick(); drv_b(0, 0);
        mid(); chk("drn_isolated_settle", isolated_o, 0);
        tick(); drv_w(1, 32'hee, 1);
        mid();
        chk("drn_isolated_set", isolated_o, 1);
        chk("iso_w_ready_blocked", slv_resp.w_ready, 0);
        chk("iso_mst_w_valid_blocked", mst_req.w_valid, 0);

        // Release from ISOLATED: held AW/AR accepted once back in NORMAL
        tick(); drv_w(0, 0, 0); isolate_i = 1'b0;
        mid();
        chk("rel_aw_ready_still_blocked", slv_resp.aw_ready, 0);
        chk("rel_isolated_still", isolated_o, 1);
        tick(); drv_w(1, 32'hf0, 1); exp_w.push_back(32'hf0);
        mid();
        chk("rel_aw_ready", slv_resp.aw_ready, 1);
        chk("rel_ar_ready", slv_resp.ar_ready, 1);
        chk("rel_isolated_clear", isolated_o, 0);
        tick(); drv_aw(0, 0, 0); drv_ar(0, 0, 0); drv_w(0, 0, 0);
        drv_b(1, 4'd6); drv_r(1, 32'hf8, 1); exp_b.push_back(6); exp_r.push_back(32'hf8);
        tick(); drv_b(0, 0); drv_r(0, 0, 0);

        // Stalled AW across the isolate request
        tick(); mst_resp.aw_ready = 1'b0; drv_aw(1, 32'h600, 0); exp_aw.push_back(32'h600);
        mid();
        chk("stl_mst_aw_valid", mst_req.aw_valid, 1);
        chk("stl_aw_ready", slv_resp.aw_ready, 0);
        tick(); isolate_i = 1'b1;
        mid(); chk("stl_mst_aw_valid_req", mst_req.aw_valid, 1);
        tick();
        mid();
        chk("stl_mst_aw_valid_drain", mst_req.aw_valid, 1);
        chk("stl_isolated_busy", isolated_o, 0);
        tick(); mst_resp.aw_ready = 1'b1;
        mid(); chk("stl_aw_ready_done", slv_resp.aw_ready, 1);
        tick(); drv_aw(0, 0, 0); drv_w(1, 32'h66, 1); exp_w.push_back(32'h66);
        mid(); chk("stl_w_ready_drain", slv_resp.w_ready, 1);
        tick(); drv_w(0, 0, 0); drv_b(1, 4'd7); exp_b.push_back(7);
        mid(); chk("stl_isolated_on_b", isolated_o, 0);
        tick(); drv_b(0, 0);
        mid(); chk("stl_isolated_settle", isolated_o, 0);
        tick();
        mid(); chk("stl_isolated_set", isolated_o, 1);

        // Abort: isolate pulsed three cycles while writes are outstanding
        tick(); isolate_i = 1'b0;
        tick(); drv_aw(1, 32'h700, 1); drv_w(1, 32'h70, 0);
        exp_aw.push_back(32'h700); exp_w.push_back(32'h70);
        mid(); chk("abt_aw_ready", slv_resp.aw_ready, 1);
        tick(); drv_aw(0, 0, 0); drv_w(0, 0, 0); isolate_i = 1'b1;
        tick(); drv_ar(1, 32'h720, 0); exp_ar.push_back(32'h720);
        mid();
        chk("abt_ar_blocked_0", slv_resp.ar_ready, 0);
        chk("abt_isolated_0", isolated_o, 0);
        tick();
        mid();
        chk("abt_ar_blocked_1", slv_resp.ar_ready, 0);
        chk("abt_isolated_1", isolated_o, 0);
        tick(); isolate_i = 1'b0;
        mid();
        chk("abt_ar_blocked_2", slv_resp.ar_ready, 0);
        chk("abt_isolated_2", isolated_o, 0);
        tick(); drv_w(1, 32'h71, 1); exp_w.push_back(32'h71);
        mid();
        chk("abt_ar_ready", slv_resp.ar_ready, 1);
        chk("abt_isolated_3", isolated_o, 0);
        tick(); drv_ar(0, 0, 0); drv_w(0, 0, 0);
        drv_b(1, 4'd8); drv_r(1, 32'h7e, 1); exp_b.push_back(8); exp_r.push_back(32'h7e);
        tick(); drv_b(0, 0); drv_r(0, 0, 0);
        mid(); chk("abt_isolated_end", isolated_o, 0);

        // Reset mid-drain with the write limit reached
        tick(); drv_aw(1, 32'h800, 0); exp_aw.push_back(32'h800);
        tick(); drv_aw(1, 32'h810, 0); exp_aw.push_back(32'h810);
        tick(); drv_aw(0, 0, 0); isolate_i = 1'b1;
        tick();
        mid();
        chk("rmd_isolated_busy", isolated_o, 0);
        chk("rmd_aw_ready_drain", slv_resp.aw_ready, 0);
        tick(); rst_ni = 1'b0;
        tick(); rst_ni = 1'b1;
        mid();
        chk("rmd_isolated_after_rst", isolated_o, 0);
        chk("rmd_aw_ready_normal", slv_resp.aw_ready, 1);
        tick();
        mid(); chk("rmd_aw_ready_drain2", slv_resp.aw_ready, 0);
        tick();
        mid(); chk("rmd_isolated_counts_cleared", isolated_o, 1);
        tick(); isolate_i = 1'b0;
        tick();
        tick();

        chk("aw_queue_left", exp_aw.size(), 0);
        chk("w_queue_left", exp_w.size(), 0);
        chk("ar_queue_left", exp_ar.size(), 0);
        chk("b_queue_left", exp_b.size(), 0);
        chk("r_queue_left", exp_r.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
